axistream_unpack: RTL and testbench



---
 rtl/axistream_pkg.sv | 24 ++
 rtl/axistream_keep_sel.sv | 36 +++
 rtl/axistream_unpack.sv | 124 ++++++++++++
 tb/tb_axistream_unpack.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axistream_pkg.sv
// axistream_pkg: shared helpers for the AXI-Stream packer/unpacker.
// Count width and lane ordering used by both directions.
package axistream_pkg;

  function automatic int clog2_cnt(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int lane_idx(
    input int i,
    input int n,
    input bit be
  );
    return be ? (n - 1 - i) : i;
  endfunction

  function automatic int out_lane(
    input int n,
    input bit be
  );
    return lane_idx(0, n, be);
  endfunction

endpackage

// File: rtl/axistream_keep_sel.sv
// axistream_keep_sel: picks the next kept lane from a keep mask.
// Also flags when exactly one kept word remains.
module axistream_keep_sel
  import axistream_pkg::*;
#(
  parameter int NUM_PACK   = 4,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [NUM_PACK-1:0]         mask,
  output logic [$clog2(NUM_PACK)-1:0] lane,
  output logic                        one_left
);

  localparam int LW = $clog2(NUM_PACK);

  logic           found;
  logic [LW-1:0]  j;

  // First set bit in emission order
  always_comb begin
    lane  = '0;
    found = 1'b0;
    j     = '0;
    for (int i = 0; i < NUM_PACK; i++) begin
      j = LW'(lane_idx(i, NUM_PACK, BIG_ENDIAN));
      if (!found && mask[j]) begin
        lane  = j;
        found = 1'b1;
      end
    end
  end

  assign one_left = (mask != '0) &&
    ((mask & (mask - NUM_PACK'(1))) == '0);

endmodule

// File: rtl/axistream_unpack.sv
// axistream_unpack: one wide beat in, NUM_PACK narrow beats out.
// Optional AXISTREAM_UNPACK_TKEEP_EN adds src_tkeep and a null-last error.
module axistream_unpack
  import axistream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PACK   = 4,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           src_tvalid,
  output logic                           src_tready,
  input  logic [DATA_WIDTH*NUM_PACK-1:0] src_tdata,
  input  logic                           src_tlast,
`ifdef AXISTREAM_UNPACK_TKEEP_EN
  input  logic [NUM_PACK-1:0]            src_tkeep,
  output logic                           tkeep_null_last_err,
`endif
  output logic                           dest_tvalid,
  input  logic                           dest_tready,
  output logic [DATA_WIDTH-1:0]          dest_tdata,
  output logic                           dest_tlast
);

  localparam int WW = DATA_WIDTH * NUM_PACK;

  logic [WW-1:0] data_buf;
  logic          last_r;
  logic          src_hs;
  logic          dest_hs;

  assign src_hs  = src_tvalid && src_tready;
  assign dest_hs = dest_tvalid && dest_tready;

`ifdef AXISTREAM_UNPACK_TKEEP_EN

  localparam int LW = $clog2(NUM_PACK);

  logic [NUM_PACK-1:0] mask;
  logic [LW-1:0]       lane;
  logic                one_left;
  logic                err_r;

  axistream_keep_sel #(
    .NUM_PACK   (NUM_PACK),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_keep_sel (
    .mask     (mask),
    .lane     (lane),
    .one_left (one_left)
  );

  assign dest_tvalid = |mask;
  assign src_tready  = rst_n &&
    ((mask == '0) || (one_left && dest_tready));
  assign dest_tlast  = last_r && one_left;
  assign dest_tdata  = data_buf[lane*DATA_WIDTH +: DATA_WIDTH];
  assign tkeep_null_last_err = err_r;

  // Kept-word mask: reload on accept, clear the sent lane
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask  <= '0;
      err_r <= 1'b0;
    end else begin
      err_r <= src_hs && (src_tkeep == '0) && src_tlast;
      if (src_hs)
        mask <= src_tkeep;
      else if (dest_hs)
        mask <= mask & ~(NUM_PACK'(1) << lane);
    end
  end

  // Payload capture; lanes are selected, never shifted
  always_ff @(posedge clk) begin
    if (src_hs) begin
      data_buf <= src_tdata;
      last_r   <= src_tlast;
    end
  end

`else

  localparam int CW = clog2_cnt(NUM_PACK);
  localparam int OUT_LO =
    out_lane(NUM_PACK, BIG_ENDIAN) * DATA_WIDTH;
  localparam logic [CW-1:0] CNT_FULL = CW'(NUM_PACK);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] cnt;

  assign dest_tvalid = (cnt != '0);
  assign src_tready  = rst_n &&
    ((cnt == '0) || ((cnt == CNT_ONE) && dest_tready));
  assign dest_tlast  = last_r && (cnt == CNT_ONE);
  assign dest_tdata  = data_buf[OUT_LO +: DATA_WIDTH];

  // Remaining-word count; reload beats the final decrement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (src_hs)
      cnt <= CNT_FULL;
    else if (dest_hs)
      cnt <= cnt - CNT_ONE;
  end

  // Payload capture and shift toward the output lane
  always_ff @(posedge clk) begin
    if (src_hs) begin
      data_buf <= src_tdata;
      last_r   <= src_tlast;
    end else if (dest_hs) begin
      if (BIG_ENDIAN)
        data_buf <= data_buf << DATA_WIDTH;
      else
        data_buf <= data_buf >> DATA_WIDTH;
    end
  end

`endif

endmodule

// File: tb/tb_axistream_unpack.sv
// tb_axistream_unpack: LE and BE unpackers against a word-queue model.
// Directed order/back-to-back/backpressure/reset plus random traffic.
module tb_axistream_unpack;

  localparam int DW = 8;
  localparam int NP = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          src_tvalid = 1'b0;
  logic          src_tlast = 1'b0;
  logic          dest_tready = 1'b0;
  logic [DW*NP-1:0] src_tdata = '0;

  logic          rdy_le, vld_le, last_le;
  logic          rdy_be, vld_be, last_be;
  logic [DW-1:0] d_le, d_be;
  logic [10:0]   obs_le, obs_be;

  logic [8:0]    q_le[$];
  logic [8:0]    q_be[$];
  int            n_chk = 0;
  int            n_fail = 0;
  int            cyc = 0;
  bit            last_acc = 1'b0;

  assign obs_le = {rdy_le, vld_le, last_le, d_le};
  assign obs_be = {rdy_be, vld_be, last_be, d_be};

  always #5 clk = ~clk;

  axistream_unpack #(
    .DATA_WIDTH (DW),
    .NUM_PACK   (NP),
    .BIG_ENDIAN (1'b0)
  ) u_le (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_tvalid  (src_tvalid),
    .src_tready  (rdy_le),
    .src_tdata   (src_tdata),
    .src_tlast   (src_tlast),
    .dest_tvalid (vld_le),
    .dest_tready (dest_tready),
    .dest_tdata  (d_le),
    .dest_tlast  (last_le)
  );

  axistream_unpack #(
    .DATA_WIDTH (DW),
    .NUM_PACK   (NP),
    .BIG_ENDIAN (1'b1)
  ) u_be (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_tvalid  (src_tvalid),
    .src_tready  (rdy_be),
    .src_tdata   (src_tdata),
    .src_tlast   (src_tlast),
    .dest_tvalid (vld_be),
    .dest_tready (dest_tready),
    .dest_tdata  (d_be),
    .dest_tlast  (last_be)
  );

  // Expected {ready, valid, last, data} from pending words
  function automatic logic [10:0] expv(input logic [8:0] q[$]);
    logic r;
    logic v;
    r = rst_n &&
      ((q.size() == 0) || (q.size() == 1 && dest_tready));
    v = (q.size() != 0);
    return {r, v, v ? q[0][8] : 1'b0, v ? q[0][7:0] : 8'h00};
  endfunction

  // Apply this cycle's transfers to the model, then clock
  task automatic advance();
    bit mrdy;
    bit pop;
    bit acc;
    mrdy = rst_n &&
      ((q_le.size() == 0) || (q_le.size() == 1 && dest_tready));
    pop = rst_n && (q_le.size() != 0) && dest_tready;
    acc = src_tvalid && mrdy;
    if (!rst_n) begin
      q_le.delete();
      q_be.delete();
    end
    if (pop) begin
      void'(q_le.pop_front());
      void'(q_be.pop_front());
    end
    if (acc) begin
      for (int i = 0; i < NP; i++) begin
        q_le.push_back({src_tlast && (i == NP-1),
                        src_tdata[i*DW +: DW]});
        q_be.push_back({src_tlast && (i == NP-1),
                        src_tdata[(NP-1-i)*DW +: DW]});
      end
    end
    last_acc = acc;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    logic [10:0] e_le, e_be;
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      e_le = expv(q_le);
      e_be = expv(q_be);
      n_chk += 2;
      if (obs_le[10:8] !== e_le[10:8]) begin
        n_fail++;
        $display("FAIL reset le cyc=%0d got=%h exp=%h",
                 cyc, obs_le, e_le);
      end
      if (obs_be[10:8] !== e_be[10:8]) begin
        n_fail++;
        $display("FAIL reset be cyc=%0d got=%h exp=%h",
                 cyc, obs_be, e_be);
      end
      advance();
    end
    rst_n = 1'b1;
  endtask

  task automatic test_order();
    logic [10:0] e_le, e_be;
    src_tdata   = 32'h44332211;
    src_tlast   = 1'b1;
    src_tvalid  = 1'b1;
    dest_tready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      e_le = expv(q_le);
      e_be = expv(q_be);
      n_chk += 2;
      if (e_le[9] ? (obs_le !== e_le)
                  : (obs_le[10:8] !== e_le[10:8])) begin
        n_fail++;
        $display("FAIL order le c=%0d got=%h exp=%h",
                 c, obs_le, e_le);
      end
      if (e_be[9] ? (obs_be !== e_be)
                  : (obs_be[10:8] !== e_be[10:8])) begin
        n_fail++;
        $display("FAIL order be c=%0d got=%h exp=%h",
                 c, obs_be, e_be);
      end
      advance();
      if (last_acc) src_tvalid = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] e_le, e_be;
    int nacc;
    nacc        = 0;
    src_tdata   = 32'h44332211;
    src_tlast   = 1'b0;
    src_tvalid  = 1'b1;
    dest_tready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      e_le = expv(q_le);
      e_be = expv(q_be);
      n_chk += 2;
      if (e_le[9] ? (obs_le !== e_le)
                  : (obs_le[10:8] !== e_le[10:8])) begin
        n_fail++;
        $display("FAIL b2b le c=%0d got=%h exp=%h",
                 c, obs_le, e_le);
      end
      if (e_be[9] ? (obs_be !== e_be)
                  : (obs_be[10:8] !== e_be[10:8])) begin
        n_fail++;
        $display("FAIL b2b be c=%0d got=%h exp=%h",
                 c, obs_be, e_be);
      end
      if (c == 0 || c == 4) begin
        n_chk++;
        if (rdy_le !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_ready c=%0d got=%b exp=1",
                   c, rdy_le);
        end
      end
      if (c >= 1 && c <= 8) begin
        n_chk++;
        if (vld_le !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_gap c=%0d got=%b exp=1", c, vld_le);
        end
      end
      advance();
      if (last_acc) begin
        nacc++;
        if (nacc == 1) begin
          src_tdata = 32'h88776655;
          src_tlast = 1'b1;
        end else begin
          src_tvalid = 1'b0;
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [10:0] e_le, e_be;
    src_tdata  = 32'h44332211;
    src_tlast  = 1'b1;
    src_tvalid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      dest_tready = !(c >= 2 && c <= 4);
      @(negedge clk);
      e_le = expv(q_le);
      e_be = expv(q_be);
      n_chk += 2;
      if (e_le[9] ? (obs_le !== e_le)
                  : (obs_le[10:8] !== e_le[10:8])) begin
        n_fail++;
        $display("FAIL bp le c=%0d got=%h exp=%h",
                 c, obs_le, e_le);
      end
      if (e_be[9] ? (obs_be !== e_be)
                  : (obs_be[10:8] !== e_be[10:8])) begin
        n_fail++;
        $display("FAIL bp be c=%0d got=%h exp=%h",
                 c, obs_be, e_be);
      end
      if (c >= 2 && c <= 4) begin
        n_chk++;
        if (d_le !== 8'h22 || rdy_le !== 1'b0 || vld_le !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_hold c=%0d got=%h/%b exp=22/0",
                   c, d_le, rdy_le);
        end
      end
      advance();
      if (last_acc) src_tvalid = 1'b0;
    end
    dest_tready = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [10:0] e_le, e_be;
    src_tdata   = 32'h44332211;
    src_tlast   = 1'b1;
    src_tvalid  = 1'b1;
    dest_tready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      advance();
      if (last_acc) src_tvalid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({vld_le, vld_be, rdy_le, rdy_be, last_le, last_be}
        !== 6'b0) begin
      n_fail++;
      $display("FAIL rst_mid got=%b%b%b%b exp=0000",
               vld_le, vld_be, rdy_le, rdy_be);
    end
    advance();
    rst_n      = 1'b1;
    src_tdata  = 32'hDDCCBBAA;
    src_tlast  = 1'b0;
    src_tvalid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      e_le = expv(q_le);
      e_be = expv(q_be);
      n_chk += 2;
      if (e_le[9] ? (obs_le !== e_le)
                  : (obs_le[10:8] !== e_le[10:8])) begin
        n_fail++;
        $display("FAIL rst_mid le c=%0d got=%h exp=%h",
                 c, obs_le, e_le);
      end
      if (e_be[9] ? (obs_be !== e_be)
                  : (obs_be[10:8] !== e_be[10:8])) begin
        n_fail++;
        $display("FAIL rst_mid be c=%0d got=%h exp=%h",
                 c, obs_be, e_be);
      end
      advance();
      if (last_acc) src_tvalid = 1'b0;
    end
  endtask

  task automatic test_random();
    logic [10:0] e_le, e_be;
    for (int c = 0; c < 400; c++) begin
      src_tvalid  = ($urandom_range(3) != 0);
      src_tdata   = $urandom;
      src_tlast   = $urandom_range(1);
      dest_tready = ($urandom_range(3) != 0);
      @(negedge clk);
      e_le = expv(q_le);
      e_be = expv(q_be);
      n_chk += 2;
      if (e_le[9] ? (obs_le !== e_le)
                  : (obs_le[10:8] !== e_le[10:8])) begin
        n_fail++;
        $display("FAIL rand le c=%0d got=%h exp=%h",
                 c, obs_le, e_le);
      end
      if (e_be[9] ? (obs_be !== e_be)
                  : (obs_be[10:8] !== e_be[10:8])) begin
        n_fail++;
        $display("FAIL rand be c=%0d got=%h exp=%h",
                 c, obs_be, e_be);
      end
      advance();
    end
    src_tvalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_order();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
